// File: rtl/config_cmd_parser.sv
// Byte-serial parser for "CONFIG <SUB> [arg [arg]]" lines from uart_rx.
// Each good line yields one config_valid beat; each malformed line yields one parse_error pulse.
module config_cmd_parser #(
   parameter int MAX_LINE     = 32,
   parameter int IDLE_TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       config_valid,
   output logic [2:0] config_type,
   output logic [7:0] config_value1,
   output logic [7:0] config_value2,
   output logic       parse_error,
   output logic       busy
);

   localparam int LW = $clog2(MAX_LINE + 2);
   localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

   localparam logic [2:0] T_MAX    = 3'd0;
   localparam logic [2:0] T_RANGE  = 3'd1;
   localparam logic [2:0] T_COUNT  = 3'd2;
   localparam logic [2:0] T_SHOW   = 3'd3;
   localparam logic [2:0] T_SCALAR = 3'd4;

   localparam logic [47:0] K_CONFIG = "CONFIG";
   localparam logic [47:0] K_MAX    = 48'("MAX");
   localparam logic [47:0] K_RANGE  = 48'("RANGE");
   localparam logic [47:0] K_COUNT  = 48'("COUNT");
   localparam logic [47:0] K_SHOW   = 48'("SHOW");
   localparam logic [47:0] K_SCALAR = 48'("SCALAR");

   typedef enum logic [2:0] {S_IDLE, S_KW, S_SUB, S_ARG, S_FLUSH} state_t;

   function automatic logic [1:0] arg_need(input logic [2:0] t);
      case (t)
         T_RANGE: arg_need = 2'd2;
         T_SHOW:  arg_need = 2'd0;
         default: arg_need = 2'd1;
      endcase
   endfunction

   state_t          r_state, w_state_next;
   logic [47:0]     r_tok, w_tok_next;
   logic [2:0]      r_tok_len, w_tok_len_next;
   logic [2:0]      r_sub, w_sub_next;
   logic [1:0]      r_arg_cnt, w_arg_cnt_next;
   logic            r_in_arg, w_in_arg_next;
   logic            r_neg, w_neg_next;
   logic [8:0]      r_mag, w_mag_next;
   logic [1:0]      r_ndig, w_ndig_next;
   logic [7:0]      r_arg0, w_arg0_next;
   logic [7:0]      r_arg1, w_arg1_next;
   logic [LW-1:0]   r_len, w_len_next;
   logic [TW-1:0]   r_tmo, w_tmo_next;
   logic            r_valid, w_valid_next;
   logic            r_err, w_err_next;
   logic [2:0]      r_type_o, w_type_o_next;
   logic [7:0]      r_v1_o, w_v1_o_next;
   logic [7:0]      r_v2_o, w_v2_o_next;

   logic [7:0]      w_ch;
   logic            w_is_eol, w_is_space, w_is_letter, w_is_digit, w_is_minus;
   logic [47:0]     w_tok_shift;
   logic [LW-1:0]   w_len_inc;
   logic            w_len_over;
   logic [TW-1:0]   w_tmo_inc;
   logic [9:0]      w_mag_new;
   logic            w_mag_bad;
   logic [7:0]      w_arg_val;
   logic [1:0]      w_argc_final;
   logic [7:0]      w_fin_v1, w_fin_v2;
   logic            w_sub_hit;
   logic [2:0]      w_sub_code;

   assign w_ch        = (rx_data >= "a" && rx_data <= "z") ? rx_data - 8'd32 : rx_data;
   assign w_is_eol    = (w_ch == 8'h0D) || (w_ch == 8'h0A);
   assign w_is_space  = (w_ch == 8'h20);
   assign w_is_letter = (w_ch >= "A") && (w_ch <= "Z");
   assign w_is_digit  = (w_ch >= "0") && (w_ch <= "9");
   assign w_is_minus  = (w_ch == "-");
   assign w_tok_shift = {r_tok[39:0], w_ch};
   assign w_len_inc   = r_len + LW'(1);
   assign w_len_over  = (w_len_inc > LW'(MAX_LINE));
   assign w_tmo_inc   = r_tmo + TW'(1);

   // r_mag never exceeds 99 when a further digit arrives, so 10 bits cannot overflow.
   assign w_mag_new   = 10'(r_mag) * 10'd10 + 10'(w_ch[3:0]);
   assign w_mag_bad   = r_neg ? (w_mag_new > 10'd128) : (w_mag_new > 10'd127);
   assign w_arg_val   = r_neg ? (8'd0 - r_mag[7:0]) : r_mag[7:0];

   // An argument still being collected when EOL arrives is folded into the emitted values.
   assign w_argc_final = r_arg_cnt + {1'b0, r_in_arg};
   assign w_fin_v1     = (r_in_arg && r_arg_cnt == 2'd0) ? w_arg_val : r_arg0;
   assign w_fin_v2     = (r_in_arg && r_arg_cnt == 2'd1) ? w_arg_val : r_arg1;

   always_comb begin
      w_sub_hit  = 1'b1;
      w_sub_code = T_MAX;
      case (r_tok)
         K_MAX:    w_sub_code = T_MAX;
         K_RANGE:  w_sub_code = T_RANGE;
         K_COUNT:  w_sub_code = T_COUNT;
         K_SHOW:   w_sub_code = T_SHOW;
         K_SCALAR: w_sub_code = T_SCALAR;
         default:  w_sub_hit  = 1'b0;
      endcase
   end

   always_comb begin
      w_state_next   = r_state;
      w_tok_next     = r_tok;
      w_tok_len_next = r_tok_len;
      w_sub_next     = r_sub;
      w_arg_cnt_next = r_arg_cnt;
      w_in_arg_next  = r_in_arg;
      w_neg_next     = r_neg;
      w_mag_next     = r_mag;
      w_ndig_next    = r_ndig;
      w_arg0_next    = r_arg0;
      w_arg1_next    = r_arg1;
      w_len_next     = r_len;
      w_tmo_next     = r_tmo;
      w_valid_next   = 1'b0;
      w_err_next     = 1'b0;
      w_type_o_next  = r_type_o;
      w_v1_o_next    = r_v1_o;
      w_v2_o_next    = r_v2_o;

      if (rx_valid) begin
         w_tmo_next = '0;
         if (w_is_eol) begin
            w_len_next   = '0;
            w_state_next = S_IDLE;
            case (r_state)
               S_IDLE: ;
               S_SUB: begin
                  if (r_tok_len == 3'd0 || !w_sub_hit || arg_need(w_sub_code) != 2'd0) begin
                     w_err_next = 1'b1;
                  end else begin
                     w_valid_next  = 1'b1;
                     w_type_o_next = w_sub_code;
                     w_v1_o_next   = 8'd0;
                     w_v2_o_next   = 8'd0;
                  end
               end
               S_ARG: begin
                  if ((r_in_arg && r_ndig == 2'd0) || w_argc_final != arg_need(r_sub)) begin
                     w_err_next = 1'b1;
                  end else begin
                     w_valid_next  = 1'b1;
                     w_type_o_next = r_sub;
                     w_v1_o_next   = w_fin_v1;
                     w_v2_o_next   = w_fin_v2;
                  end
               end
               default: w_err_next = 1'b1;
            endcase
         end else begin
            if (r_state != S_FLUSH) w_len_next = w_len_inc;
            if (r_state != S_FLUSH && w_len_over) begin
               w_state_next = S_FLUSH;
            end else begin
               case (r_state)
                  S_IDLE: begin
                     if (w_is_letter) begin
                        w_state_next   = S_KW;
                        w_tok_next     = {40'd0, w_ch};
                        w_tok_len_next = 3'd1;
                        w_arg_cnt_next = 2'd0;
                        w_in_arg_next  = 1'b0;
                        w_arg0_next    = 8'd0;
                        w_arg1_next    = 8'd0;
                     end else if (!w_is_space) begin
                        w_state_next = S_FLUSH;
                     end
                  end
                  S_KW, S_SUB: begin
                     if (w_is_space) begin
                        if (r_state == S_KW) begin
                           if (r_tok == K_CONFIG) begin
                              w_state_next   = S_SUB;
                              w_tok_next     = '0;
                              w_tok_len_next = 3'd0;
                           end else begin
                              w_state_next = S_FLUSH;
                           end
                        end else if (r_tok_len != 3'd0) begin
                           if (w_sub_hit) begin
                              w_sub_next    = w_sub_code;
                              w_state_next  = S_ARG;
                              w_in_arg_next = 1'b0;
                           end else begin
                              w_state_next = S_FLUSH;
                           end
                        end
                     end else if (w_is_letter && r_tok_len < 3'd6) begin
                        w_tok_next     = w_tok_shift;
                        w_tok_len_next = r_tok_len + 3'd1;
                     end else begin
                        w_state_next = S_FLUSH;
                     end
                  end
                  S_ARG: begin
                     if (w_is_space) begin
                        if (r_in_arg) begin
                           if (r_ndig == 2'd0) begin
                              w_state_next = S_FLUSH;
                           end else begin
                              if (r_arg_cnt == 2'd0) w_arg0_next = w_arg_val;
                              else                   w_arg1_next = w_arg_val;
                              w_arg_cnt_next = r_arg_cnt + 2'd1;
                              w_in_arg_next  = 1'b0;
                           end
                        end
                     end else if (w_is_minus) begin
                        if (r_in_arg || r_arg_cnt == 2'd2) begin
                           w_state_next = S_FLUSH;
                        end else begin
                           w_in_arg_next = 1'b1;
                           w_neg_next    = 1'b1;
                           w_mag_next    = 9'd0;
                           w_ndig_next   = 2'd0;
                        end
                     end else if (w_is_digit) begin
                        if (!r_in_arg) begin
                           if (r_arg_cnt == 2'd2) begin
                              w_state_next = S_FLUSH;
                           end else begin
                              w_in_arg_next = 1'b1;
                              w_neg_next    = 1'b0;
                              w_mag_next    = {5'd0, w_ch[3:0]};
                              w_ndig_next   = 2'd1;
                           end
                        end else if (r_ndig == 2'd3 || w_mag_bad) begin
                           w_state_next = S_FLUSH;
                        end else begin
                           w_mag_next  = w_mag_new[8:0];
                           w_ndig_next = r_ndig + 2'd1;
                        end
                     end else begin
                        w_state_next = S_FLUSH;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end else if (IDLE_TIMEOUT != 0 && r_state != S_IDLE) begin
         // A stalled partial line is dropped without any pulse.
         if (w_tmo_inc == TW'(IDLE_TIMEOUT)) begin
            w_state_next = S_IDLE;
            w_tmo_next   = '0;
            w_len_next   = '0;
         end else begin
            w_tmo_next = w_tmo_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_tok     <= '0;
         r_tok_len <= '0;
         r_sub     <= '0;
         r_arg_cnt <= '0;
         r_in_arg  <= 1'b0;
         r_neg     <= 1'b0;
         r_mag     <= '0;
         r_ndig    <= '0;
         r_arg0    <= '0;
         r_arg1    <= '0;
         r_len     <= '0;
         r_tmo     <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_type_o  <= '0;
         r_v1_o    <= '0;
         r_v2_o    <= '0;
      end else begin
         r_state   <= w_state_next;
         r_tok     <= w_tok_next;
         r_tok_len <= w_tok_len_next;
         r_sub     <= w_sub_next;
         r_arg_cnt <= w_arg_cnt_next;
         r_in_arg  <= w_in_arg_next;
         r_neg     <= w_neg_next;
         r_mag     <= w_mag_next;
         r_ndig    <= w_ndig_next;
         r_arg0    <= w_arg0_next;
         r_arg1    <= w_arg1_next;
         r_len     <= w_len_next;
         r_tmo     <= w_tmo_next;
         r_valid   <= w_valid_next;
         r_err     <= w_err_next;
         r_type_o  <= w_type_o_next;
         r_v1_o    <= w_v1_o_next;
         r_v2_o    <= w_v2_o_next;
      end
   end

   assign config_valid  = r_valid;
   assign parse_error   = r_err;
   assign config_type   = r_type_o;
   assign config_value1 = r_v1_o;
   assign config_value2 = r_v2_o;
   assign busy          = (r_state != S_IDLE);

endmodule
